mem_access_stage: RTL and testbench

//  MEM pipeline stage: producer of the ALU_result/read_data/MemtoReg bundle consumed by write-back.

---
 rtl/mem_access_stage_pkg.sv | 26 ++
 rtl/mem_access_stage_watchdog.sv | 39 +++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: data width, FSM states, held-bundle layout.
package mem_access_stage_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Copy of the EX/MEM bundle kept stable for the whole memory access.
  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] store_data;
    logic              is_load;
    logic              is_store;
    logic              mem_to_reg;
    logic              reg_write;
  } hold_t;

  // Only the two low address bits decide word alignment.
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags the last allowed one.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // TIMEOUT >= 2, so the counter is at least one bit and TIMEOUT-1 always fits.
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear wins, otherwise step while enabled and saturate at the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs the data-memory req/ack handshake and registers the MEM/WB bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int RD_W    = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [WORD_W-1:0] ex_alu_result,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_MemtoReg,
  input  logic              ex_RegWrite,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [WORD_W-1:0] wb_alu_result,
  output logic [WORD_W-1:0] wb_read_data,
  output logic              wb_MemtoReg,
  output logic              wb_RegWrite,
  output logic [RD_W-1:0]   wb_rd,
  output logic              mem_err
);

  state_e            state_q, state_d;
  hold_t             hold_q, hold_d;
  logic [RD_W-1:0]   hold_rd_q, hold_rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [WORD_W-1:0] wb_alu_result_q, wb_alu_result_d;
  logic [WORD_W-1:0] wb_read_data_q, wb_read_data_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              mem_err_q, mem_err_d;

  logic ex_mem_op;
  logic stall_c;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // A load+store combination is a load; any memory op needs the handshake.
  assign ex_mem_op = ex_mem_read | ex_mem_write;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Next-state, bundle capture and completion logic for the IDLE/ACCESS handshake.
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    hold_rd_d       = hold_rd_q;
    wb_valid_d      = 1'b0;
    wb_alu_result_d = wb_alu_result_q;
    wb_read_data_d  = wb_read_data_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    mem_err_d       = mem_err_q;
    stall_c         = 1'b0;
    wd_clear        = 1'b1;
    wd_enable       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_mem_op && word_aligned(ex_alu_result[1:0])) begin
            stall_c           = 1'b1;
            hold_d.alu_result = ex_alu_result;
            hold_d.store_data = ex_store_data;
            hold_d.is_load    = ex_mem_read;
            hold_d.is_store   = ex_mem_write & ~ex_mem_read;
            hold_d.mem_to_reg = ex_MemtoReg;
            hold_d.reg_write  = ex_RegWrite;
            hold_rd_d         = ex_rd;
            state_d           = ST_ACCESS;
          end else begin
            wb_valid_d      = 1'b1;
            wb_alu_result_d = ex_alu_result;
            wb_read_data_d  = '0;
            wb_mem_to_reg_d = ex_MemtoReg;
            wb_reg_write_d  = ex_RegWrite;
            wb_rd_d         = ex_rd;
            if (ex_mem_op) begin
              mem_err_d = 1'b1;
            end
          end
        end
      end
      ST_ACCESS: begin
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        if (mem_ack || wd_expired) begin
          wb_valid_d      = 1'b1;
          wb_alu_result_d = hold_q.alu_result;
          wb_read_data_d  = (mem_ack && hold_q.is_load) ? mem_rdata : '0;
          wb_mem_to_reg_d = hold_q.mem_to_reg;
          wb_reg_write_d  = hold_q.reg_write;
          wb_rd_d         = hold_rd_q;
          if (!mem_ack) begin
            mem_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, held bundle, MEM/WB bundle and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      hold_q          <= '0;
      hold_rd_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_alu_result_q <= '0;
      wb_read_data_q  <= '0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      hold_rd_q       <= hold_rd_d;
      wb_valid_q      <= wb_valid_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      mem_err_q       <= mem_err_d;
    end
  end

  // Stall is forced low while reset is held so upstream never freezes during reset.
  assign stall     = stall_c & ~rst;
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_req & hold_q.is_store;
  assign mem_addr  = mem_req ? {hold_q.alu_result[WORD_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? hold_q.store_data : '0;

  assign wb_valid      = wb_valid_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_MemtoReg   = wb_mem_to_reg_q;
  assign wb_RegWrite   = wb_reg_write_q;
  assign wb_rd         = wb_rd_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level model plus directed literal checks.
module tb_mem_access_stage;

  localparam int RD_W    = 6;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [31:0]     ex_alu_result;
  logic [31:0]     ex_store_data;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_MemtoReg;
  logic            ex_RegWrite;
  logic [RD_W-1:0] ex_rd;
  logic            stall;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            wb_valid;
  logic [31:0]     wb_alu_result;
  logic [31:0]     wb_read_data;
  logic            wb_MemtoReg;
  logic            wb_RegWrite;
  logic [RD_W-1:0] wb_rd;
  logic            mem_err;

  always #5 clk = ~clk;

  mem_access_stage #(.RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .mem_err(mem_err)
  );

  int total = 0;
  int bad   = 0;

  // Outstanding access: bundle, planned memory latency and remaining non-final ACCESS cycles.
  bit              m_busy;
  int              m_left;
  int              m_lat;
  bit              m_timeout;
  logic [31:0]     m_alu, m_sdata, m_rdata;
  bit              m_load, m_store, m_m2r, m_rw;
  logic [RD_W-1:0] m_rd;

  // Expected MEM/WB bundle and sticky error.
  bit              e_valid, e_m2r, e_rw, e_err;
  logic [31:0]     e_alu, e_rdata;
  logic [RD_W-1:0] e_rd;

  // Memory plan for whatever instruction is on ex_* now, and responder bookkeeping.
  int          plan_lat;
  logic [31:0] plan_rdata;
  int          req_age;

  // Values seen at the most recent check point.
  logic        obs_stall, obs_req, obs_valid;
  logic        obs_last_we;
  logic [31:0] obs_last_addr, obs_last_wdata;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_left = 0; m_lat = 0; m_timeout = 0;
    m_alu = 0; m_sdata = 0; m_rdata = 0;
    m_load = 0; m_store = 0; m_m2r = 0; m_rw = 0; m_rd = 0;
    e_valid = 0; e_m2r = 0; e_rw = 0; e_err = 0; e_alu = 0; e_rdata = 0; e_rd = 0;
  endtask

  task automatic checkOutput();
    bit memop;
    bit issue;
    memop = ex_mem_read || ex_mem_write;
    issue = !m_busy && ex_valid && memop && (ex_alu_result[1:0] == 2'b00);
    checkVal("stall", stall, issue || (m_busy && m_left != 0));
    checkVal("mem_req", mem_req, m_busy);
    checkVal("mem_we", mem_we, m_busy && m_store);
    checkVal("mem_addr", mem_addr, m_busy ? m_alu : 32'h0);
    checkVal("mem_wdata", mem_wdata, m_busy ? m_sdata : 32'h0);
    checkVal("wb_valid", wb_valid, e_valid);
    checkVal("wb_alu_result", wb_alu_result, e_alu);
    checkVal("wb_read_data", wb_read_data, e_rdata);
    checkVal("wb_MemtoReg", wb_MemtoReg, e_m2r);
    checkVal("wb_RegWrite", wb_RegWrite, e_rw);
    checkVal("wb_rd", wb_rd, e_rd);
    checkVal("mem_err", mem_err, e_err);
  endtask

  task automatic modelAdvance();
    bit memop;
    memop = ex_mem_read || ex_mem_write;
    if (m_busy) begin
      if (m_left == 0) begin
        e_valid = 1; e_alu = m_alu; e_m2r = m_m2r; e_rw = m_rw; e_rd = m_rd;
        e_rdata = (m_load && !m_timeout) ? m_rdata : 32'h0;
        if (m_timeout) e_err = 1;
        m_busy = 0;
      end else begin
        m_left--;
        e_valid = 0;
      end
    end else if (ex_valid) begin
      if (memop && ex_alu_result[1:0] == 2'b00) begin
        m_busy = 1;
        m_alu = ex_alu_result; m_sdata = ex_store_data;
        m_load = ex_mem_read; m_store = ex_mem_write && !ex_mem_read;
        m_m2r = ex_MemtoReg; m_rw = ex_RegWrite; m_rd = ex_rd;
        m_lat = plan_lat; m_rdata = plan_rdata;
        m_timeout = (plan_lat > TIMEOUT - 1);
        m_left = m_timeout ? TIMEOUT - 1 : plan_lat;
        e_valid = 0;
      end else begin
        e_valid = 1; e_alu = ex_alu_result; e_rdata = 0;
        e_m2r = ex_MemtoReg; e_rw = ex_RegWrite; e_rd = ex_rd;
        if (memop) e_err = 1;
      end
    end else begin
      e_valid = 0;
    end
  endtask

  // Called at a falling edge with ex_* already driven; returns at the next falling edge.
  task automatic stepCycle();
    if (mem_req) begin
      mem_ack   = (req_age == m_lat);
      mem_rdata = mem_ack ? m_rdata : $urandom();
      req_age++;
    end else begin
      req_age   = 0;
      mem_ack   = ($urandom_range(7, 0) == 0);
      mem_rdata = $urandom();
    end
    #2;
    obs_stall = stall; obs_req = mem_req; obs_valid = wb_valid;
    if (mem_req) begin
      obs_last_we = mem_we; obs_last_addr = mem_addr; obs_last_wdata = mem_wdata;
    end
    checkOutput();
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input bit rd_op, input bit wr_op,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input bit m2r, input bit rw, input logic [RD_W-1:0] rd,
                               input int lat, input logic [31:0] rdat);
    ex_valid = v; ex_mem_read = rd_op; ex_mem_write = wr_op;
    ex_alu_result = alu; ex_store_data = sd;
    ex_MemtoReg = m2r; ex_RegWrite = rw; ex_rd = rd;
    plan_lat = lat; plan_rdata = rdat;
    stepCycle();
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, '0, 0, 32'h0);
  endtask

  // Issues one instruction, then idles until it completes; counts stall/req/valid cycles.
  task automatic runInstr(input bit rd_op, input bit wr_op, input logic [31:0] alu,
                          input logic [31:0] sd, input bit m2r, input bit rw,
                          input logic [RD_W-1:0] rd, input int lat, input logic [31:0] rdat,
                          output int n_stall, output int n_req, output int n_valid);
    int guard;
    n_valid = 0;
    applyStimulus(1, rd_op, wr_op, alu, sd, m2r, rw, rd, lat, rdat);
    n_stall = int'(obs_stall);
    n_req   = int'(obs_req);
    guard   = 0;
    while (m_busy && guard < 40) begin
      idleStep();
      n_stall += int'(obs_stall);
      n_req   += int'(obs_req);
      n_valid += int'(obs_valid);
      guard++;
    end
    if (m_busy) begin
      total++;
      bad++;
      $display("[TB] FAIL completion_bound: still busy after %0d cycles", guard);
    end
  endtask

  initial begin
    int ns, nr, nv, pulses;
    int kind, pick, lat;
    bit v, rd_op, wr_op;
    logic [31:0] alu;

    rst = 1;
    ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_MemtoReg = 0; ex_RegWrite = 0; ex_rd = 0; mem_ack = 0; mem_rdata = 0;
    req_age = 0; plan_lat = 0; plan_rdata = 0;
    obs_last_we = 0; obs_last_addr = 0; obs_last_wdata = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    $display("[TB] reset state");
    idleStep();
    checkVal("rst_wb_valid", obs_valid, 0);
    checkVal("rst_mem_req", obs_req, 0);
    checkVal("rst_mem_err", mem_err, 0);

    $display("[TB] ADD passes with one cycle latency");
    runInstr(0, 0, 32'h1234, 32'h0, 0, 1, 6'd5, 0, 32'h0, ns, nr, nv);
    checkVal("add_stall_cycles", ns, 0);
    checkVal("add_wb_valid", wb_valid, 1);
    checkVal("add_wb_alu", wb_alu_result, 32'h1234);
    checkVal("add_wb_rd", wb_rd, 5);
    checkVal("add_wb_regwrite", wb_RegWrite, 1);
    idleStep();

    $display("[TB] load 0x40, ack in fourth ACCESS cycle");
    runInstr(1, 0, 32'h40, 32'h0, 1, 1, 6'd9, 3, 32'hDEADBEEF, ns, nr, nv);
    checkVal("load_stall_cycles", ns, 4);
    checkVal("load_wb_data", wb_read_data, 32'hDEADBEEF);
    checkVal("load_wb_memtoreg", wb_MemtoReg, 1);
    checkVal("load_wb_alu", wb_alu_result, 32'h40);
    pulses = nv;
    idleStep(); pulses += int'(obs_valid);
    idleStep(); pulses += int'(obs_valid);
    checkVal("load_valid_pulses", pulses, 1);

    $display("[TB] store 0x80");
    runInstr(0, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 6'd3, 2, 32'h0, ns, nr, nv);
    checkVal("store_req_cycles", nr, 3);
    checkVal("store_mem_we", obs_last_we, 1);
    checkVal("store_mem_addr", obs_last_addr, 32'h80);
    checkVal("store_mem_wdata", obs_last_wdata, 32'hA5A5A5A5);
    checkVal("store_wb_data", wb_read_data, 32'h0);
    idleStep();

    $display("[TB] load with no ack runs into the watchdog");
    checkVal("pre_timeout_err", mem_err, 0);
    runInstr(1, 0, 32'h100, 32'h0, 1, 1, 6'd4, NEVER, 32'h12345678, ns, nr, nv);
    checkVal("timeout_req_cycles", nr, 16);
    checkVal("timeout_stall_cycles", ns, 16);
    checkVal("timeout_wb_valid", wb_valid, 1);
    checkVal("timeout_wb_data", wb_read_data, 32'h0);
    repeat (3) idleStep();
    checkVal("timeout_err_sticky", mem_err, 1);

    $display("[TB] reset in the middle of an access");
    applyStimulus(1, 1, 0, 32'h200, 32'h0, 1, 1, 6'd2, NEVER, 32'h0);
    repeat (3) idleStep();
    rst = 1; ex_valid = 0; mem_ack = 0;
    #1;
    checkVal("midrst_mem_req", mem_req, 0);
    checkVal("midrst_stall", stall, 0);
    checkVal("midrst_wb_valid", wb_valid, 0);
    checkVal("midrst_mem_err", mem_err, 0);
    modelReset();
    req_age = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    runInstr(0, 0, 32'hCAFE, 32'h0, 0, 1, 6'd11, 0, 32'h0, ns, nr, nv);
    checkVal("post_rst_add_valid", wb_valid, 1);
    checkVal("post_rst_add_alu", wb_alu_result, 32'hCAFE);
    idleStep();

    $display("[TB] misaligned load");
    runInstr(1, 0, 32'h42, 32'h0, 1, 1, 6'd6, 0, 32'h99, ns, nr, nv);
    checkVal("misaligned_req_cycles", nr, 0);
    checkVal("misaligned_wb_valid", wb_valid, 1);
    checkVal("misaligned_wb_data", wb_read_data, 32'h0);
    checkVal("misaligned_err", mem_err, 1);
    idleStep();

    $display("[TB] back-to-back load then ADD");
    applyStimulus(1, 1, 0, 32'h300, 32'h0, 1, 1, 6'd7, 0, 32'h11112222);
    applyStimulus(1, 1, 0, 32'h300, 32'h0, 1, 1, 6'd7, 0, 32'h11112222);
    checkVal("b2b_load_valid", wb_valid, 1);
    checkVal("b2b_load_data", wb_read_data, 32'h11112222);
    applyStimulus(1, 0, 0, 32'h55, 32'h0, 0, 1, 6'd8, 0, 32'h0);
    checkVal("b2b_add_valid", wb_valid, 1);
    checkVal("b2b_add_alu", wb_alu_result, 32'h55);
    checkVal("b2b_add_rd", wb_rd, 8);
    idleStep();

    $display("[TB] randomized traffic");
    rst = 1;
    #1;
    modelReset();
    req_age = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 700; i++) begin
      kind  = $urandom_range(5, 0);
      pick  = $urandom_range(7, 0);
      v     = ($urandom_range(9, 0) != 0);
      alu   = $urandom();
      rd_op = 0;
      wr_op = 0;
      case (kind)
        2: begin rd_op = 1; alu[1:0] = 2'b00; end
        3: begin wr_op = 1; alu[1:0] = 2'b00; end
        4: begin rd_op = 1; wr_op = 1; alu[1:0] = 2'b00; end
        5: begin
          rd_op = $urandom_range(1, 0);
          wr_op = !rd_op;
          alu[1:0] = 2'($urandom_range(3, 1));
        end
        default: ;
      endcase
      case (pick)
        4:       lat = 5;
        5:       lat = TIMEOUT - 2;
        6:       lat = TIMEOUT - 1;
        7:       lat = NEVER;
        default: lat = pick;
      endcase
      applyStimulus(v, rd_op, wr_op, alu, $urandom(), $urandom_range(1, 0),
                    $urandom_range(1, 0), RD_W'($urandom()), lat, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
